// File: rtl/clk_div_multi_pkg.sv
// Shared types and helpers for the multi-channel clock divider.
// The CLKDIV_LOAD_EN macro (see clk_div_multi) adds runtime-loadable divisors.
package clk_div_pkg;

  localparam int CNT_W_DEF = 16;

  typedef logic [CNT_W_DEF-1:0] div_t;

  // Counter value from which the square wave is high: ceil(div/2).
  // Gives floor(div/2) high cycles and ceil(div/2) low cycles per period.
  function automatic logic [31:0] sq_thresh(input logic [31:0] div);
    logic [32:0] sum;
    sum = {1'b0, div} + 33'd1;
    return sum[32:1];
  endfunction

endpackage

// File: rtl/clk_div_multi_chan.sv
// One divider channel: counter, registered square wave and tick strobe.
// With CLKDIV_LOAD_EN the divisor is a register reset to DIV_RST; otherwise it is DIV_RST.
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int               CNT_W   = 16,
  parameter logic [CNT_W-1:0] DIV_RST = CNT_W'(50)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en_i,
  input  logic             clr_i,
`ifdef CLKDIV_LOAD_EN
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
`endif
  output logic             sq_o,
  output logic             tick_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sq_q, sq_d;
  logic             tick_q, tick_d;
  logic [CNT_W-1:0] div;
  logic             load_w;
  logic [31:0]      thr;

`ifdef CLKDIV_LOAD_EN
  logic [CNT_W-1:0] div_q, div_d;

  assign load_w = load_i;
  assign div    = div_q;

  always_comb begin
    div_d = div_q;
    if (load_i) div_d = load_val_i;
  end

  always_ff @(posedge clk) begin
    if (reset) div_q <= DIV_RST;
    else       div_q <= div_d;
  end
`else
  assign load_w = 1'b0;
  assign div    = DIV_RST;
`endif

  assign thr = sq_thresh(32'(div));

  // Priority: load > clr > en > hold; a load also restarts the phase.
  always_comb begin
    cnt_d  = cnt_q;
    sq_d   = sq_q;
    tick_d = 1'b0;
    if (load_w || clr_i) begin
      cnt_d = '0;
      sq_d  = 1'b0;
    end else if (en_i) begin
      if (div <= CNT_W'(1)) begin
        // Degenerate divisor: strobe every enabled cycle, no square wave.
        cnt_d  = '0;
        sq_d   = 1'b0;
        tick_d = 1'b1;
      end else begin
        if (cnt_q == div - CNT_W'(1)) begin
          cnt_d  = '0;
          tick_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        sq_d = (32'(cnt_d) >= thr);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      sq_q   <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      sq_q   <= sq_d;
      tick_q <= tick_d;
    end
  end

  assign sq_o   = sq_q;
  assign tick_o = tick_q;

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel clock divider: NUM_CH independent square-wave/tick channels from clk.
// Define CLKDIV_LOAD_EN to add load_div/load_val and per-channel divisor registers.
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter int                        NUM_CH   = 2,
  parameter int                        CNT_W    = CNT_W_DEF,
  parameter logic [NUM_CH*CNT_W-1:0]   DIV_INIT = {16'd50, 16'd100}
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_CH-1:0]       en,
  input  logic [NUM_CH-1:0]       clr,
`ifdef CLKDIV_LOAD_EN
  input  logic [NUM_CH-1:0]       load_div,
  input  logic [NUM_CH*CNT_W-1:0] load_val,
`endif
  output logic [NUM_CH-1:0]       sq_out,
  output logic [NUM_CH-1:0]       tick
);

  // Channel i takes bits [i*CNT_W +: CNT_W] of DIV_INIT and load_val.
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_chan
    clk_div_chan #(
      .CNT_W   (CNT_W),
      .DIV_RST (DIV_INIT[gi*CNT_W +: CNT_W])
    ) u_chan (
      .clk        (clk),
      .reset      (reset),
      .en_i       (en[gi]),
      .clr_i      (clr[gi]),
`ifdef CLKDIV_LOAD_EN
      .load_i     (load_div[gi]),
      .load_val_i (load_val[gi*CNT_W +: CNT_W]),
`endif
      .sq_o       (sq_out[gi]),
      .tick_o     (tick[gi])
    );
  end

endmodule
